// File: rtl/trap_controller.sv
// Machine-mode trap entry / mret return sequencer for the 5-stage pipeline.
// Owns mepc, mcause, mtvec and the mstatus trap fields, and drives flush_trap plus the fetch redirect.
module trap_controller #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0100,
  parameter logic [31:0] IRQ_CAUSE    = 32'h8000_000B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        trap_illegal_instr,
  input  logic        trap_csr_access_violation,
  input  logic        trap_instr_addr_misaligned,
  input  logic        trap_load_store_misaligned,
  input  logic        ext_irq,
  input  logic        mret_req,
  input  logic        mtvec_we,
  input  logic [31:0] mtvec_wdata,
  input  logic        mie_we,
  input  logic        mie_wdata,
  output logic        flush_trap,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  privilege,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtvec,
  output logic        mie,
  output logic        busy
);

  localparam logic [1:0] PRIV_M     = 2'b11;
  localparam logic [1:0] PRIV_U     = 2'b00;
  localparam logic [3:0] LAST_FLUSH = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIRECT,
    S_RETURN
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_count;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtvec;
  logic        r_mie;
  logic        r_mpie;
  logic [1:0]  r_mpp;
  logic [1:0]  r_priv;

  logic        w_accept;
  logic        w_syncTrap;
  logic        w_mretM;
  logic        w_mretU;
  logic        w_irq;
  logic        w_takeTrap;
  logic        w_takeMret;
  logic [31:0] w_cause;

  assign w_accept   = (r_state == S_IDLE) && !stall;
  assign w_syncTrap = ex_valid && (trap_illegal_instr || trap_csr_access_violation ||
                                   trap_instr_addr_misaligned || trap_load_store_misaligned);
  assign w_mretU    = ex_valid && mret_req && (r_priv != PRIV_M);
  assign w_mretM    = ex_valid && mret_req && (r_priv == PRIV_M);
  assign w_irq      = ext_irq && r_mie;

  // Synchronous faults beat mret, and a legal mret beats the pending interrupt.
  assign w_takeTrap = w_accept && (w_syncTrap || w_mretU || (w_irq && !w_mretM));
  assign w_takeMret = w_accept && w_mretM && !w_syncTrap;

  always_comb begin
    w_cause = IRQ_CAUSE;
    if (ex_valid) begin
      if (trap_illegal_instr)              w_cause = 32'd1;
      else if (trap_csr_access_violation)  w_cause = 32'd2;
      else if (trap_instr_addr_misaligned) w_cause = 32'd3;
      else if (trap_load_store_misaligned) w_cause = 32'd4;
      else if (mret_req)                   w_cause = 32'd1;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    flush_trap     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_takeTrap)      w_nextState = S_FLUSH;
        else if (w_takeMret) w_nextState = S_RETURN;
      end
      S_FLUSH: begin
        flush_trap = 1'b1;
        if (r_count == LAST_FLUSH) w_nextState = S_REDIRECT;
      end
      S_REDIRECT: begin
        flush_trap     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = r_mtvec & 32'hFFFF_FFFC;
        w_nextState    = S_IDLE;
      end
      S_RETURN: begin
        flush_trap     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = r_mepc;
        w_nextState    = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
    end else begin
      r_state <= w_nextState;
      if (r_state == S_FLUSH) r_count <= r_count + 4'd1;
      else                    r_count <= 4'd0;
    end
  end

  // mtvec is writable at any time; REDIRECT reads the register, so a same-cycle write lands afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mepc   <= 32'd0;
      r_mcause <= 32'd0;
      r_mtvec  <= RESET_MTVEC;
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mpp    <= PRIV_M;
      r_priv   <= PRIV_M;
    end else begin
      if (mtvec_we) r_mtvec <= mtvec_wdata & 32'hFFFF_FFFC;
      if (w_takeTrap) begin
        r_mepc   <= ex_pc;
        r_mcause <= w_cause;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
        r_mpp    <= r_priv;
        r_priv   <= PRIV_M;
      end else if (w_takeMret) begin
        r_priv   <= r_mpp;
        r_mie    <= r_mpie;
        r_mpie   <= 1'b1;
        r_mpp    <= PRIV_U;
      end else if (mie_we) begin
        r_mie    <= mie_wdata;
      end
    end
  end

  assign privilege = r_priv;
  assign mepc      = r_mepc;
  assign mcause    = r_mcause;
  assign mtvec     = r_mtvec;
  assign mie       = r_mie;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// Directed table-driven bench for trap_controller, plus hand sequences for stall, REDIRECT-time mtvec write and mid-sequence reset.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        trap_illegal_instr;
  logic        trap_csr_access_violation;
  logic        trap_instr_addr_misaligned;
  logic        trap_load_store_misaligned;
  logic        ext_irq;
  logic        mret_req;
  logic        mtvec_we;
  logic [31:0] mtvec_wdata;
  logic        mie_we;
  logic        mie_wdata;
  logic        flush_trap;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  privilege;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtvec;
  logic        mie;
  logic        busy;

  trap_controller #(
    .FLUSH_CYCLES (2),
    .RESET_MTVEC  (32'h0000_0100),
    .IRQ_CAUSE    (32'h8000_000B)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .stall                      (stall),
    .ex_valid                   (ex_valid),
    .ex_pc                      (ex_pc),
    .trap_illegal_instr         (trap_illegal_instr),
    .trap_csr_access_violation  (trap_csr_access_violation),
    .trap_instr_addr_misaligned (trap_instr_addr_misaligned),
    .trap_load_store_misaligned (trap_load_store_misaligned),
    .ext_irq                    (ext_irq),
    .mret_req                   (mret_req),
    .mtvec_we                   (mtvec_we),
    .mtvec_wdata                (mtvec_wdata),
    .mie_we                     (mie_we),
    .mie_wdata                  (mie_wdata),
    .flush_trap                 (flush_trap),
    .redirect_valid             (redirect_valid),
    .redirect_pc                (redirect_pc),
    .privilege                  (privilege),
    .mepc                       (mepc),
    .mcause                     (mcause),
    .mtvec                      (mtvec),
    .mie                        (mie),
    .busy                       (busy)
  );

  always #5 clk = ~clk;

  // ctl = {stall, ex_valid, ext_irq, mret_req, mtvec_we, mie_we, mie_wdata}
  // traps = {illegal, csr_violation, instr_misaligned, ls_misaligned}
  // exp = {flush_trap, redirect_valid, busy, mie}
  typedef struct {
    logic [6:0]  ctl;
    logic [3:0]  traps;
    logic [31:0] pc;
    logic [31:0] mtD;
    logic [3:0]  exp;
    logic [1:0]  priv;
    logic [31:0] rpc;
    logic [31:0] mepcExp;
    logic [31:0] mcauseExp;
    logic [31:0] mtvecExp;
  } vec_t;

  vec_t vecs[$];
  int   vectorCount = 0;
  int   miscompareCount = 0;

  function automatic vec_t mk(input logic [6:0] ctl, input logic [3:0] traps,
                              input logic [31:0] pc, input logic [31:0] mtD,
                              input logic [3:0] exp, input logic [1:0] priv,
                              input logic [31:0] rpc, input logic [31:0] mepcExp,
                              input logic [31:0] mcauseExp, input logic [31:0] mtvecExp);
    vec_t v;
    v.ctl = ctl; v.traps = traps; v.pc = pc; v.mtD = mtD; v.exp = exp; v.priv = priv;
    v.rpc = rpc; v.mepcExp = mepcExp; v.mcauseExp = mcauseExp; v.mtvecExp = mtvecExp;
    return v;
  endfunction

  task automatic checkField(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      miscompareCount++;
      $display("[TB] FAIL %s (check %0d): got %0h, want %0h", name, idx, got, want);
    end
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    vectorCount++;
    checkField("flush_trap",     idx, 32'(flush_trap),     32'(v.exp[3]));
    checkField("redirect_valid", idx, 32'(redirect_valid), 32'(v.exp[2]));
    checkField("busy",           idx, 32'(busy),           32'(v.exp[1]));
    checkField("mie",            idx, 32'(mie),            32'(v.exp[0]));
    checkField("privilege",      idx, 32'(privilege),      32'(v.priv));
    checkField("redirect_pc",    idx, redirect_pc,         v.rpc);
    checkField("mepc",           idx, mepc,                v.mepcExp);
    checkField("mcause",         idx, mcause,              v.mcauseExp);
    checkField("mtvec",          idx, mtvec,               v.mtvecExp);
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    vectorCount++;
    checkField(name, vectorCount, got, want);
  endtask

  task automatic driveIdle();
    stall = 1'b0; ex_valid = 1'b0; ex_pc = 32'd0; ext_irq = 1'b0; mret_req = 1'b0;
    trap_illegal_instr = 1'b0; trap_csr_access_violation = 1'b0;
    trap_instr_addr_misaligned = 1'b0; trap_load_store_misaligned = 1'b0;
    mtvec_we = 1'b0; mtvec_wdata = 32'd0; mie_we = 1'b0; mie_wdata = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    {stall, ex_valid, ext_irq, mret_req, mtvec_we, mie_we, mie_wdata} = v.ctl;
    {trap_illegal_instr, trap_csr_access_violation,
     trap_instr_addr_misaligned, trap_load_store_misaligned} = v.traps;
    ex_pc       = v.pc;
    mtvec_wdata = v.mtD;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat;
    bit  seen;

    driveIdle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Illegal instruction at 0x40: three flush cycles, redirect to 0x100 on the third
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b0000, 2'd3, 32'h0,   32'h0,   32'h0, 32'h100));
    vecs.push_back(mk(7'b0100000, 4'h8, 32'h40,  32'h0, 4'b1010, 2'd3, 32'h0,   32'h40,  32'h1, 32'h100));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b1010, 2'd3, 32'h0,   32'h40,  32'h1, 32'h100));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b1110, 2'd3, 32'h100, 32'h40,  32'h1, 32'h100));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b0000, 2'd3, 32'h0,   32'h40,  32'h1, 32'h100));
    // Illegal + ls-misaligned + irq with mie=1: cause 1, irq not retaken since mie drops
    vecs.push_back(mk(7'b0000011, 4'h0, 32'h0,   32'h0, 4'b0001, 2'd3, 32'h0,   32'h40,  32'h1, 32'h100));
    vecs.push_back(mk(7'b0110000, 4'h9, 32'h44,  32'h0, 4'b1010, 2'd3, 32'h0,   32'h44,  32'h1, 32'h100));
    vecs.push_back(mk(7'b0110000, 4'h8, 32'h88,  32'h0, 4'b1010, 2'd3, 32'h0,   32'h44,  32'h1, 32'h100));
    vecs.push_back(mk(7'b0010000, 4'h0, 32'h0,   32'h0, 4'b1110, 2'd3, 32'h100, 32'h44,  32'h1, 32'h100));
    vecs.push_back(mk(7'b0010000, 4'h0, 32'h0,   32'h0, 4'b0000, 2'd3, 32'h0,   32'h44,  32'h1, 32'h100));
    vecs.push_back(mk(7'b0010000, 4'h0, 32'h0,   32'h0, 4'b0000, 2'd3, 32'h0,   32'h44,  32'h1, 32'h100));
    // CSR violation at 0x200 with mie=1, then mret in M twice (second drops to U), then mret in U traps
    vecs.push_back(mk(7'b0000011, 4'h0, 32'h0,   32'h0, 4'b0001, 2'd3, 32'h0,   32'h44,  32'h1, 32'h100));
    vecs.push_back(mk(7'b0100000, 4'h4, 32'h200, 32'h0, 4'b1010, 2'd3, 32'h0,   32'h200, 32'h2, 32'h100));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b1010, 2'd3, 32'h0,   32'h200, 32'h2, 32'h100));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b1110, 2'd3, 32'h100, 32'h200, 32'h2, 32'h100));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b0000, 2'd3, 32'h0,   32'h200, 32'h2, 32'h100));
    vecs.push_back(mk(7'b0101000, 4'h0, 32'h200, 32'h0, 4'b1111, 2'd3, 32'h200, 32'h200, 32'h2, 32'h100));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b0001, 2'd3, 32'h0,   32'h200, 32'h2, 32'h100));
    vecs.push_back(mk(7'b0101000, 4'h0, 32'h200, 32'h0, 4'b1111, 2'd0, 32'h200, 32'h200, 32'h2, 32'h100));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b0001, 2'd0, 32'h0,   32'h200, 32'h2, 32'h100));
    vecs.push_back(mk(7'b0101000, 4'h0, 32'h204, 32'h0, 4'b1010, 2'd3, 32'h0,   32'h204, 32'h1, 32'h100));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b1010, 2'd3, 32'h0,   32'h204, 32'h1, 32'h100));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b1110, 2'd3, 32'h100, 32'h204, 32'h1, 32'h100));
    // mret during REDIRECT is ignored; the next IDLE cycle accepts one back-to-back
    vecs.push_back(mk(7'b0101000, 4'h0, 32'h208, 32'h0, 4'b0000, 2'd3, 32'h0,   32'h204, 32'h1, 32'h100));
    vecs.push_back(mk(7'b0101000, 4'h0, 32'h20c, 32'h0, 4'b1111, 2'd0, 32'h204, 32'h204, 32'h1, 32'h100));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b0001, 2'd0, 32'h0,   32'h204, 32'h1, 32'h100));
    vecs.push_back(mk(7'b0000000, 4'h8, 32'h500, 32'h0, 4'b0001, 2'd0, 32'h0,   32'h204, 32'h1, 32'h100));
    // Interrupt from U without ex_valid, mtvec write 0x303 during FLUSH redirects to 0x300
    vecs.push_back(mk(7'b0010000, 4'h0, 32'h80,  32'h0,   4'b1010, 2'd3, 32'h0,   32'h80, 32'h8000000B, 32'h100));
    vecs.push_back(mk(7'b0000100, 4'h0, 32'h0,   32'h303, 4'b1010, 2'd3, 32'h0,   32'h80, 32'h8000000B, 32'h300));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0,   4'b1110, 2'd3, 32'h300, 32'h80, 32'h8000000B, 32'h300));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0,   4'b0000, 2'd3, 32'h0,   32'h80, 32'h8000000B, 32'h300));
    vecs.push_back(mk(7'b0100000, 4'h8, 32'h10,  32'h0,   4'b1010, 2'd3, 32'h0,   32'h10, 32'h1, 32'h300));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0,   4'b1010, 2'd3, 32'h0,   32'h10, 32'h1, 32'h300));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0,   4'b1110, 2'd3, 32'h300, 32'h10, 32'h1, 32'h300));
    vecs.push_back(mk(7'b0000100, 4'h0, 32'h0,   32'h405, 4'b0000, 2'd3, 32'h0,   32'h10, 32'h1, 32'h404));
    // Lower-priority causes 3 and 4
    vecs.push_back(mk(7'b0100000, 4'h3, 32'h14,  32'h0, 4'b1010, 2'd3, 32'h0,   32'h14, 32'h3, 32'h404));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b1010, 2'd3, 32'h0,   32'h14, 32'h3, 32'h404));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b1110, 2'd3, 32'h404, 32'h14, 32'h3, 32'h404));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b0000, 2'd3, 32'h0,   32'h14, 32'h3, 32'h404));
    vecs.push_back(mk(7'b0100000, 4'h1, 32'h18,  32'h0, 4'b1010, 2'd3, 32'h0,   32'h18, 32'h4, 32'h404));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b1010, 2'd3, 32'h0,   32'h18, 32'h4, 32'h404));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b1110, 2'd3, 32'h404, 32'h18, 32'h4, 32'h404));
    vecs.push_back(mk(7'b0000000, 4'h0, 32'h0,   32'h0, 4'b0000, 2'd3, 32'h0,   32'h18, 32'h4, 32'h404));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Stall holds off acceptance, then is ignored once the sequence runs
    @(negedge clk);
    driveIdle();
    stall = 1'b1; ex_valid = 1'b1; trap_illegal_instr = 1'b1; ex_pc = 32'h60;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkValue("stall_busy", 32'(busy), 32'd0);
    end
    checkValue("stall_mepc", mepc, 32'h18);
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk);
    #1;
    checkValue("stall_release_busy", 32'(busy), 32'd1);
    checkValue("stall_release_mepc", mepc, 32'h60);
    checkValue("stall_release_mcause", mcause, 32'h1);
    @(negedge clk);
    driveIdle();
    stall = 1'b1;
    @(posedge clk);
    #1;
    checkValue("stall_in_flush", 32'({flush_trap, redirect_valid}), 32'b10);
    @(posedge clk);
    #1;
    checkValue("stall_redirect_valid", 32'(redirect_valid), 32'd1);
    checkValue("stall_redirect_pc", redirect_pc, 32'h404);
    // mtvec write during REDIRECT must not change this redirect target
    @(negedge clk);
    mtvec_we = 1'b1; mtvec_wdata = 32'h123;
    #1;
    checkValue("redirect_pre_write_pc", redirect_pc, 32'h404);
    @(posedge clk);
    #1;
    checkValue("post_redirect_busy", 32'(busy), 32'd0);
    checkValue("post_redirect_mtvec", mtvec, 32'h120);

    // Reset in the middle of FLUSH aborts at once
    @(negedge clk);
    driveIdle();
    ex_valid = 1'b1; trap_illegal_instr = 1'b1; ex_pc = 32'h70;
    @(posedge clk);
    #1;
    checkValue("pre_reset_busy", 32'(busy), 32'd1);
    @(negedge clk);
    driveIdle();
    reset = 1'b0;
    #1;
    checkValue("reset_flush", 32'({flush_trap, redirect_valid, busy}), 32'd0);
    checkValue("reset_priv", 32'(privilege), 32'd3);
    checkValue("reset_mtvec", mtvec, 32'h100);
    checkValue("reset_csrs", mepc | mcause | 32'(mie), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    @(negedge clk);
    ex_valid = 1'b1; trap_illegal_instr = 1'b1; ex_pc = 32'h74;
    @(posedge clk);
    #1;
    @(negedge clk);
    driveIdle();
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      if (redirect_valid) seen = 1'b1;
    end
    checkValue("after_reset_redirect_seen", 32'(seen), 32'd1);
    checkValue("after_reset_latency", 32'(lat), 32'd2);
    checkValue("after_reset_redirect_pc", redirect_pc, 32'h100);
    checkValue("after_reset_mepc", mepc, 32'h74);
    checkValue("after_reset_mcause", mcause, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
